// File: rtl/modexp_controller.sv
// Right-to-left square-and-multiply sequencer for modular exponentiation.
// Drives one shared modular multiplier over a start/done handshake and keeps all intermediate state.
module modexp_controller #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 128,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic [CNT_WIDTH-1:0] op_count,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_n,
  input  logic                 mul_done,
  input  logic [WIDTH-1:0]     mul_result
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] EVAL     = 3'd2;
  localparam logic [2:0] MUL_WAIT = 3'd3;
  localparam logic [2:0] SQR_WAIT = 3'd4;
  localparam logic [2:0] FINISH   = 3'd5;

  logic [2:0]           state;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     n;
  logic [EXP_WIDTH-1:0] e;
  logic                 op_phase;

  // acc, b and e only change on an accepted mul_done, so the operand mux
  // below stays stable from issue in EVAL through the whole wait state.
  assign op_phase  = (state == EVAL) || (state == MUL_WAIT) || (state == SQR_WAIT);
  assign mul_start = (state == EVAL) && (e != '0);
  assign mul_a     = op_phase ? (e[0] ? acc : b) : '0;
  assign mul_b     = op_phase ? b : '0;
  assign mul_n     = op_phase ? n : '0;
  assign busy      = (state == CHECK) || op_phase;
  assign done      = (state == FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      b        <= '0;
      n        <= '0;
      e        <= '0;
      err      <= 1'b0;
      result   <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= WIDTH'(1);
            b        <= base;
            e        <= exponent;
            n        <= modulus;
            op_count <= '0;
            err      <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (n == '0) begin
            result <= '0;
            err    <= 1'b1;
            state  <= FINISH;
          end else if (n == WIDTH'(1)) begin
            result <= '0;
            state  <= FINISH;
          end else begin
            state <= EVAL;
          end
        end
        EVAL: begin
          if (e == '0) begin
            result <= acc;
            state  <= FINISH;
          end else begin
            if (op_count != '1) begin
              op_count <= op_count + CNT_WIDTH'(1);
            end
            state <= e[0] ? MUL_WAIT : SQR_WAIT;
          end
        end
        MUL_WAIT: begin
          if (mul_done) begin
            acc   <= mul_result;
            e[0]  <= 1'b0;
            state <= EVAL;
          end
        end
        SQR_WAIT: begin
          if (mul_done) begin
            b     <= mul_result;
            e     <= e >> 1;
            state <= EVAL;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
